// File: rtl/hazard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_pkg                                                            |
// | Shared constants and MDU state type for the pipeline hazard control.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package hazard_pkg;

    localparam logic [1:0] FWD_RF     = 2'b00;
    localparam logic [1:0] FWD_WB     = 2'b01;
    localparam logic [1:0] FWD_ALU_M  = 2'b10;
    localparam logic [1:0] FWD_IMM_M  = 2'b11;

    localparam logic [1:0] PC_SRC_SEQ = 2'b00;

    localparam int unsigned MDU_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        WB   = 2'd2
    } mdu_state_e;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_mdu_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mdu_scoreboard                                                        |
// | Tracks the single in-flight MDU op, its pending register and strobe.  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mdu_scoreboard
    import hazard_pkg::*;
#(
    parameter int AW      = 5,
    parameter int NREG    = 32,
    parameter int MDU_LAT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_issue,
    input  logic [AW-1:0]   i_issue_rd,
    output logic [NREG-1:0] o_pending,
    output logic            o_in_busy,
    output logic            o_busy,
    output logic            o_wb_valid,
    output logic [AW-1:0]   o_wb_rd
);

    localparam logic [MDU_CNT_W-1:0] c_CNT_LOAD = MDU_CNT_W'(MDU_LAT - 1);
    localparam logic [MDU_CNT_W-1:0] c_CNT_ONE  = MDU_CNT_W'(1);

    mdu_state_e            r_state_q;
    mdu_state_e            w_state_d;
    logic [MDU_CNT_W-1:0]  r_cnt_q;
    logic [MDU_CNT_W-1:0]  w_cnt_d;
    logic [AW-1:0]         r_rd_q;
    logic [AW-1:0]         w_rd_d;
    logic [NREG-1:0]       r_pending_q;
    logic [NREG-1:0]       w_pending_d;

    always_comb begin
        w_state_d   = r_state_q;
        w_cnt_d     = r_cnt_q;
        w_rd_d      = r_rd_q;
        w_pending_d = r_pending_q;
        case (r_state_q)
            IDLE: begin
                if (i_issue) begin
                    w_state_d = BUSY;
                    w_cnt_d   = c_CNT_LOAD;
                    w_rd_d    = i_issue_rd;
                end
            end
            BUSY: begin
                w_cnt_d = r_cnt_q - c_CNT_ONE;
                if (w_cnt_d == '0) begin
                    w_state_d = WB;
                end
            end
            WB: begin
                w_pending_d[r_rd_q] = 1'b0;
                w_state_d           = IDLE;
                if (i_issue) begin
                    w_state_d = BUSY;
                    w_cnt_d   = c_CNT_LOAD;
                    w_rd_d    = i_issue_rd;
                end
            end
            default: w_state_d = IDLE;
        endcase
        // Applied after the writeback clear so a same-register reissue stays pending.
        if (i_issue && (i_issue_rd != '0)) begin
            w_pending_d[i_issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q   <= IDLE;
            r_cnt_q     <= '0;
            r_rd_q      <= '0;
            r_pending_q <= '0;
        end else begin
            r_state_q   <= w_state_d;
            r_cnt_q     <= w_cnt_d;
            r_rd_q      <= w_rd_d;
            r_pending_q <= w_pending_d;
        end
    end

    assign o_pending  = r_pending_q;
    assign o_in_busy  = (r_state_q == BUSY);
    assign o_busy     = ((r_state_q == BUSY) || ((r_state_q == WB) && !i_issue)) && !rst;
    assign o_wb_valid = (r_state_q == WB) && !rst;
    assign o_wb_rd    = r_rd_q;

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_ctrl                                                           |
// | Forwarding, stall/flush priority and stall-cycle counter for 5-stage. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int AW      = 5,
    parameter int NREG    = 32,
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rs1_d,
    input  logic [AW-1:0]    rs2_d,
    input  logic [AW-1:0]    rd_d,
    input  logic             reg_write_d,
    input  logic [AW-1:0]    rs1_e,
    input  logic [AW-1:0]    rs2_e,
    input  logic [AW-1:0]    rd_e,
    input  logic             load_e,
    input  logic             mdu_start_e,
    input  logic [1:0]       pc_src_e,
    input  logic [AW-1:0]    rd_m,
    input  logic [AW-1:0]    rd_w,
    input  logic             reg_write_m,
    input  logic             reg_write_w,
    input  logic             lui_m,
    input  logic             mem_access_m,
    input  logic             dmem_ready,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             mdu_busy,
    output logic             mdu_wb_valid,
    output logic [AW-1:0]    mdu_wb_rd,
    output logic [CNT_W-1:0] stall_cycles
);

    function automatic logic [1:0] fwd_sel(
        input logic [AW-1:0] rs,
        input logic [AW-1:0] rdm,
        input logic          wm,
        input logic          lui,
        input logic [AW-1:0] rdw,
        input logic          ww
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (rs != '0) begin
            if (wm && (rs == rdm)) begin
                sel = lui ? FWD_IMM_M : FWD_ALU_M;
            end else if (ww && (rs == rdw)) begin
                sel = FWD_WB;
            end
        end
        return sel;
    endfunction

    logic [NREG-1:0]  w_pending;
    logic             w_sb_in_busy;
    logic             w_mdu_issue;
    logic             w_mem_wait;
    logic             w_mdu_struct;
    logic             w_e_hit;
    logic             w_sb_hit;
    logic             w_use_stall;
    logic             w_branch;
    logic [CNT_W-1:0] r_stall_cycles_q;
    logic [CNT_W-1:0] w_stall_cycles_d;

    assign w_mem_wait   = mem_access_m && !dmem_ready;
    assign w_mdu_struct = mdu_start_e && w_sb_in_busy;
    assign w_e_hit      = ((rs1_d != '0) && (rs1_d == rd_e)) ||
                          ((rs2_d != '0) && (rs2_d == rd_e));
    assign w_sb_hit     = w_pending[rs1_d] || w_pending[rs2_d] ||
                          (reg_write_d && w_pending[rd_d]);
    assign w_use_stall  = (w_e_hit && (load_e || mdu_start_e)) || w_sb_hit;
    assign w_branch     = (pc_src_e != PC_SRC_SEQ);

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        if (rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
        end else if (w_mem_wait) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else if (w_mdu_struct) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else if (w_use_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
            flush_d = w_branch;
        end else if (w_branch) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign forward_a_e = rst ? FWD_RF : fwd_sel(rs1_e, rd_m, reg_write_m, lui_m, rd_w, reg_write_w);
    assign forward_b_e = rst ? FWD_RF : fwd_sel(rs2_e, rd_m, reg_write_m, lui_m, rd_w, reg_write_w);

    assign w_mdu_issue = mdu_start_e && !stall_e && !rst;

    mdu_scoreboard #(
        .AW      (AW),
        .NREG    (NREG),
        .MDU_LAT (MDU_LAT)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_issue    (w_mdu_issue),
        .i_issue_rd (rd_e),
        .o_pending  (w_pending),
        .o_in_busy  (w_sb_in_busy),
        .o_busy     (mdu_busy),
        .o_wb_valid (mdu_wb_valid),
        .o_wb_rd    (mdu_wb_rd)
    );

    always_comb begin
        w_stall_cycles_d = r_stall_cycles_q;
        if (stall_f && !(&r_stall_cycles_q)) begin
            w_stall_cycles_d = r_stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles_q <= '0;
        end else begin
            r_stall_cycles_q <= w_stall_cycles_d;
        end
    end

    assign stall_cycles = r_stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hazard_ctrl                                                        |
// | Table, directed and random checks of hazard_ctrl against a model.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_hazard_ctrl;

    localparam int L = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       reg_write_d, load_e, mdu_start_e, reg_write_m, reg_write_w;
    logic       lui_m, mem_access_m, dmem_ready;
    logic [1:0] pc_src_e;

    logic [1:0]  fa, fb, fa2, fb2;
    logic        sf, sd, se, sm, fd, fe, fm;
    logic        sf2, sd2, se2, sm2, fd2, fe2, fm2;
    logic        busy, wbv, busy2, wbv2;
    logic [4:0]  wbrd, wbrd2;
    logic [15:0] sc;
    logic [3:0]  sc2;

    hazard_ctrl #(.AW(5), .NREG(32), .MDU_LAT(L), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .reg_write_d(reg_write_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .load_e(load_e), .mdu_start_e(mdu_start_e), .pc_src_e(pc_src_e),
        .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .lui_m(lui_m), .mem_access_m(mem_access_m), .dmem_ready(dmem_ready),
        .forward_a_e(fa), .forward_b_e(fb), .stall_f(sf), .stall_d(sd),
        .stall_e(se), .stall_m(sm), .flush_d(fd), .flush_e(fe), .flush_m(fm),
        .mdu_busy(busy), .mdu_wb_valid(wbv), .mdu_wb_rd(wbrd), .stall_cycles(sc)
    );

    hazard_ctrl #(.AW(5), .NREG(32), .MDU_LAT(L), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .reg_write_d(reg_write_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .load_e(load_e), .mdu_start_e(mdu_start_e), .pc_src_e(pc_src_e),
        .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .lui_m(lui_m), .mem_access_m(mem_access_m), .dmem_ready(dmem_ready),
        .forward_a_e(fa2), .forward_b_e(fb2), .stall_f(sf2), .stall_d(sd2),
        .stall_e(se2), .stall_m(sm2), .flush_d(fd2), .flush_e(fe2), .flush_m(fm2),
        .mdu_busy(busy2), .mdu_wb_valid(wbv2), .mdu_wb_rd(wbrd2), .stall_cycles(sc2)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: one op in flight, identified by its issue cycle.
    bit         m_inflight;
    logic [4:0] m_rd;
    int         m_issue;
    int         cyc;
    int         m_stalls;

    logic [1:0] e_fa, e_fb;
    logic [6:0] e_ctrl;  // {sf, sd, se, sm, fd, fe, fm}
    logic       e_busy, e_wbv, e_accept;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (rs == 0) return 2'd0;
        if (reg_write_m && rs == rd_m) return lui_m ? 2'd3 : 2'd2;
        if (reg_write_w && rs == rd_w) return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit ref_pend(input logic [4:0] r);
        return m_inflight && (r != 0) && (r == m_rd);
    endfunction

    task automatic model_eval();
        bit mw, st, us, br, wb, in_busy;
        in_busy = m_inflight && (cyc < m_issue + L);
        wb      = m_inflight && (cyc == m_issue + L);
        mw      = mem_access_m && !dmem_ready;
        st      = mdu_start_e && in_busy;
        us      = ((((rs1_d != 0) && (rs1_d == rd_e)) || ((rs2_d != 0) && (rs2_d == rd_e)))
                   && (load_e || mdu_start_e))
                  || ref_pend(rs1_d) || ref_pend(rs2_d) || (reg_write_d && ref_pend(rd_d));
        br      = (pc_src_e != 0);
        if (rst) begin
            e_fa = 0; e_fb = 0; e_ctrl = 7'b0000111;
            e_wbv = 0; e_accept = 0; e_busy = 0;
        end else begin
            e_fa = ref_fwd(rs1_e);
            e_fb = ref_fwd(rs2_e);
            if (mw)      e_ctrl = 7'b1111000;
            else if (st) e_ctrl = 7'b1110001;
            else if (us) e_ctrl = {4'b1100, br, 2'b10};
            else if (br) e_ctrl = 7'b0000110;
            else         e_ctrl = 7'b0000000;
            e_accept = mdu_start_e && !e_ctrl[4];
            e_wbv    = wb;
            e_busy   = m_inflight && !(wb && e_accept);
        end
    endtask

    task automatic settle_check();
        model_eval();
        @(negedge clk);
        chk("fwd_a", fa, e_fa);
        chk("fwd_b", fb, e_fb);
        chk("ctrl", {sf, sd, se, sm, fd, fe, fm}, e_ctrl);
        chk("mdu_wb", {wbv, (e_wbv ? wbrd : 5'd0)}, {e_wbv, (e_wbv ? m_rd : 5'd0)});
        chk("inst4_out", {fa2, fb2, sf2, sd2, se2, sm2, fd2, fe2, fm2, wbv2, (e_wbv ? wbrd2 : 5'd0)},
            {e_fa, e_fb, e_ctrl, e_wbv, (e_wbv ? m_rd : 5'd0)});
        if (!rst) begin
            chk("mdu_busy", {busy, busy2}, {e_busy, e_busy});
            chk("stall_cnt", sc, (m_stalls > 65535) ? 65535 : m_stalls);
            chk("stall_cnt4", sc2, (m_stalls > 15) ? 15 : m_stalls);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            m_inflight = 0;
            m_stalls   = 0;
        end else begin
            if (m_inflight && cyc == m_issue + L) m_inflight = 0;
            if (e_accept) begin
                m_inflight = 1;
                m_rd       = rd_e;
                m_issue    = cyc;
            end
            if (e_ctrl[6]) m_stalls++;
        end
        cyc++;
        #1;
    endtask

    task automatic step();
        settle_check();
        advance();
    endtask

    task automatic idle_inputs();
        rs1_d = 0; rs2_d = 0; rd_d = 0; reg_write_d = 0;
        rs1_e = 0; rs2_e = 0; rd_e = 0; load_e = 0; mdu_start_e = 0; pc_src_e = 0;
        rd_m = 0; rd_w = 0; reg_write_m = 0; reg_write_w = 0; lui_m = 0;
        mem_access_m = 0; dmem_ready = 1;
    endtask

    typedef struct {
        logic [4:0] rs1_e, rs2_e, rd_m;
        logic       rw_m, lui;
        logic [4:0] rd_w;
        logic       rw_w, load;
        logic [4:0] rd_e, rs1_d, rs2_d;
        logic       mem, rdy;
        logic [1:0] pc, efa, efb;
        logic [6:0] ectrl;
    } vec_t;

    function automatic vec_t mk(input int a1e, a2e, am, awm, alui, aw, aww, ald, ade,
                                input int a1d, a2d, amem, ardy, apc, efa, efb, ectrl);
        vec_t v;
        v.rs1_e = 5'(a1e); v.rs2_e = 5'(a2e); v.rd_m = 5'(am);
        v.rw_m = 1'(awm); v.lui = 1'(alui); v.rd_w = 5'(aw); v.rw_w = 1'(aww);
        v.load = 1'(ald); v.rd_e = 5'(ade); v.rs1_d = 5'(a1d); v.rs2_d = 5'(a2d);
        v.mem = 1'(amem); v.rdy = 1'(ardy); v.pc = 2'(apc);
        v.efa = 2'(efa); v.efb = 2'(efb); v.ectrl = 7'(ectrl);
        return v;
    endfunction

    vec_t tbl[13];

    initial begin
        //            rs1e rs2e rdm rwm lui rdw rww ld rde rs1d rs2d mem rdy pc fa fb ctrl
        tbl[0]  = mk(5, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 0, 7'b0000000);
        tbl[1]  = mk(5, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 7'b0000000);
        tbl[2]  = mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 7'b0000000);
        tbl[3]  = mk(6, 6, 6, 0, 0, 6, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 7'b0000000);
        tbl[4]  = mk(7, 8, 7, 1, 0, 8, 1, 0, 0, 0, 0, 0, 1, 0, 2, 1, 7'b0000000);
        tbl[5]  = mk(9, 9, 9, 1, 0, 9, 1, 0, 0, 0, 0, 0, 1, 0, 2, 2, 7'b0000000);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 7, 0, 1, 0, 0, 0, 7'b1100010);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 0, 1, 1, 0, 0, 7'b1100110);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 7'b0000000);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 7'b0000110);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 3, 0, 1, 0, 1, 0, 0, 7'b1111000);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 7'b0000000);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 4, 4, 0, 0, 1, 0, 0, 0, 7'b0000000);

        m_inflight = 0; m_rd = 0; m_issue = 0; cyc = 0; m_stalls = 0;
        idle_inputs();
        rst = 1;
        #1;
        step();
        step();
        rst = 0;
        settle_check();
        chk("reset_state", {busy, wbv, wbrd, sc, sc2}, 0);
        advance();

        foreach (tbl[i]) begin
            idle_inputs();
            rs1_e = tbl[i].rs1_e; rs2_e = tbl[i].rs2_e; rd_m = tbl[i].rd_m;
            reg_write_m = tbl[i].rw_m; lui_m = tbl[i].lui; rd_w = tbl[i].rd_w;
            reg_write_w = tbl[i].rw_w; load_e = tbl[i].load; rd_e = tbl[i].rd_e;
            rs1_d = tbl[i].rs1_d; rs2_d = tbl[i].rs2_d; mem_access_m = tbl[i].mem;
            dmem_ready = tbl[i].rdy; pc_src_e = tbl[i].pc;
            settle_check();
            chk($sformatf("tbl%0d", i), {fa, fb, sf, sd, se, sm, fd, fe, fm},
                {tbl[i].efa, tbl[i].efb, tbl[i].ectrl});
            advance();
        end

        // MDU dependency: dependent D op held through t+L, released at t+L+1
        idle_inputs();
        mdu_start_e = 1; rd_e = 9; rs1_d = 9;
        settle_check();
        chk("mdu_issue_dep", {sd, se}, 2'b10);
        advance();
        mdu_start_e = 0; rd_e = 0;
        for (int k = 1; k <= L + 1; k++) begin
            settle_check();
            chk("mdu_dep_stall", sd, (k <= L) ? 1 : 0);
            if (k == L) chk("mdu_wb9", {wbv, wbrd}, {1'b1, 5'd9});
            advance();
        end

        // Second issue while busy: structural stall, then accepted in the WB cycle
        idle_inputs();
        mdu_start_e = 1; rd_e = 3;
        step();
        rd_e = 4;
        for (int k = 1; k <= L; k++) begin
            settle_check();
            if (k < L) chk("mdu_struct", {sf, sd, se, fm}, 4'b1111);
            else chk("mdu_accept_wb", {se, fm, wbv, wbrd, busy}, {1'b0, 1'b0, 1'b1, 5'd3, 1'b0});
            advance();
        end
        mdu_start_e = 0; rd_e = 0;
        for (int k = 1; k <= L; k++) begin
            settle_check();
            if (k == L) chk("mdu_second_wb", {wbv, wbrd}, {1'b1, 5'd4});
            advance();
        end

        // Memory wait overrides a pending branch, which flushes once memory completes
        idle_inputs();
        mem_access_m = 1; dmem_ready = 0; pc_src_e = 2'b01;
        for (int k = 0; k < 3; k++) begin
            settle_check();
            chk("mem_wait", {sf, sd, se, sm, fd, fe, fm}, 7'b1111000);
            advance();
        end
        dmem_ready = 1;
        settle_check();
        chk("mem_release_flush", {sf, sd, se, sm, fd, fe, fm}, 7'b0000110);
        advance();

        // Reset while an op is in flight abandons it
        idle_inputs();
        mdu_start_e = 1; rd_e = 12;
        step();
        mdu_start_e = 0; rd_e = 0;
        step();
        rst = 1; rs1_e = 5; rd_m = 5; reg_write_m = 1;
        settle_check();
        chk("rst_outputs", {fa, sf, sd, se, sm, fd, fe, fm, wbv}, 10'b00_0000_111_0);
        advance();
        rst = 0;
        idle_inputs();
        rs1_d = 12;
        for (int k = 1; k <= L + 1; k++) begin
            settle_check();
            chk("rst_abandon", {busy, wbv, sd}, 3'b000);
            if (k == 1) chk("rst_clear", {sc, sc2, wbrd}, 0);
            advance();
        end

        // Counter saturation in the narrow instance
        idle_inputs();
        mem_access_m = 1; dmem_ready = 0;
        for (int k = 0; k < 20; k++) step();
        idle_inputs();
        settle_check();
        chk("sat_cnt4", sc2, 4'd15);
        chk("cnt16_20", sc, 16'd20);
        advance();

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            rst          = ($urandom_range(0, 199) == 0);
            rs1_d        = 5'($urandom_range(0, 3));
            rs2_d        = 5'($urandom_range(0, 3));
            rd_d         = 5'($urandom_range(0, 3));
            reg_write_d  = 1'($urandom_range(0, 1));
            rs1_e        = 5'($urandom_range(0, 3));
            rs2_e        = 5'($urandom_range(0, 3));
            rd_e         = 5'($urandom_range(0, 3));
            rd_m         = 5'($urandom_range(0, 3));
            rd_w         = 5'($urandom_range(0, 3));
            reg_write_m  = 1'($urandom_range(0, 1));
            reg_write_w  = 1'($urandom_range(0, 1));
            lui_m        = 1'($urandom_range(0, 1));
            mdu_start_e  = ($urandom_range(0, 5) == 0);
            load_e       = !mdu_start_e && ($urandom_range(0, 3) == 0);
            pc_src_e     = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            mem_access_m = ($urandom_range(0, 3) == 0);
            dmem_ready   = 1'($urandom_range(0, 1));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised next-generation hazard controller for the 5-stage RISC-V pipeline. Resolves E-stage operand forwarding, load-use, branch flush and data-memory wait stalls. Adds a register scoreboard for a fixed-latency multi-cycle multiply/divide unit (MDU) that writes back through its own register-file port. Also provides a saturating stall-cycle counter for performance monitoring.

## Interface
- AW, default 5: register-address width.
- NREG, default 32: number of architectural registers (2**AW).
- MDU_LAT, default 4: MDU cycles from issue to writeback, range 2..15.
- CNT_W, default 16: stall counter width.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- rs1_d, rs2_d, rd_d  in  AW  decode-stage source and destination registers.
- reg_write_d  in  1  decode instruction writes rd_d.
- rs1_e, rs2_e, rd_e  in  AW  execute-stage registers.
- load_e  in  1  E instruction is a load.
- mdu_start_e  in  1  E instruction is an MDU op; it never asserts reg_write.
- pc_src_e  in  2  non-zero means a taken branch or jump in E.
- rd_m, rd_w  in  AW  memory- and writeback-stage destinations.
- reg_write_m, reg_write_w  in  1  write enables for M and W.
- lui_m  in  1  M result is the upper immediate.
- mem_access_m  in  1  M holds a load or store.
- dmem_ready  in  1  data memory completes this cycle.
- forward_a_e, forward_b_e  out  2  operand select: 00 register file, 01 W result, 10 M ALU result, 11 M immediate.
- stall_f, stall_d, stall_e, stall_m  out  1  hold the pipeline register.
- flush_d, flush_e, flush_m  out  1  insert a bubble.
- mdu_busy  out  1  an MDU op is in flight.
- mdu_wb_valid  out  1  one-cycle MDU writeback strobe.
- mdu_wb_rd  out  AW  MDU destination register, valid with mdu_wb_valid.
- stall_cycles  out  CNT_W  saturating count of cycles with stall_f high.

## Operation
- Forwarding, per operand: if rsX_e equals 0, select 00. Otherwise, if it matches rd_m and reg_write_m is high, select 11 when lui_m is high and 10 otherwise. Otherwise, if it matches rd_w and reg_write_w is high, select 01. Otherwise select 00.
- Scoreboard: the `pending` vector holds NREG bits; bit 0 is always 0.
- Conditions, evaluated every cycle:
  - mem_wait = mem_access_m and not dmem_ready.
  - mdu_struct = mdu_start_e and mdu_busy.
  - use_stall is high if rs1_d or rs2_d is non-zero, equals rd_e, and either load_e or mdu_start_e is high.
  - use_stall is also high if rs1_d, rs2_d or rd_d (with reg_write_d) hits a set pending bit. This covers RAW and WAW hazards.
  - branch = pc_src_e is non-zero.
- Priority order (highest first):
  - mem_wait: stall_f, stall_d, stall_e and stall_m high; no flushes.
  - mdu_struct: stall_f, stall_d and stall_e high; flush_m high.
  - use_stall: stall_f and stall_d high; flush_e high; a concurrent branch is also honoured, so flush_d is high as well.
  - branch: flush_d and flush_e high.
- MDU FSM states:
  - IDLE: mdu_start_e with stall_e low goes to BUSY. Latch rd_e. Set pending[rd_e] unless rd_e is 0. Load the counter with MDU_LAT-1.
  - BUSY: decrement the counter. At 0, go to WB.
  - WB: assert mdu_wb_valid, clear the pending bit, return to IDLE. An MDU op accepted in the same cycle moves directly to BUSY.
- mdu_busy is high in BUSY and WB, but not in the WB cycle where a new issue is accepted.
- Same-register set and clear in the same cycle: set wins.
- stall_cycles increments whenever stall_f is high and holds at all-ones.

## Timing
- Forward, stall and flush outputs are combinational from the inputs and the current state. There is no added latency.
- If an MDU op issues in cycle t, mdu_wb_valid is high in cycle t+MDU_LAT, and pending reads clear from t+MDU_LAT+1.
- A D instruction dependent on an MDU result first proceeds in cycle t+MDU_LAT+1.
- Reset, when rst is sampled high:
  - FSM returns to IDLE.
  - pending, the counter, mdu_wb_rd and stall_cycles are all cleared to 0.
  - While rst is high: all stall outputs are 0, flush_d, flush_e and flush_m are 1, mdu_wb_valid is 0, and forwarding selects are 00.
- An MDU op in flight when rst asserts is abandoned; no strobe is issued.

## Structure
- Package `hazard_pkg` holds:
  - forward-select constants FWD_RF, FWD_WB, FWD_ALU_M, FWD_IMM_M;
  - PC_SRC_SEQ = 2'b00;
  - MDU FSM state enum {IDLE, BUSY, WB}.
- Sub-module `mdu_scoreboard` contains the FSM, counter, pending vector and writeback strobe.
- The top level keeps the forwarding, priority logic and stall counter.

## Test plan
- rs1_e=5, rd_m=5, reg_write_m=1, lui_m=1 -> forward_a_e=11; with lui_m=0 -> 10; with rd_m=0 and rs1_e=0 -> 00.
- load_e=1, rd_e=7, rs2_d=7 -> stall_f, stall_d and flush_e high for one cycle; stall_cycles increments by 1.
- MDU issue rd_e=9 at t with MDU_LAT=4, then rs1_d=9 in D -> stalled through t+4; mdu_wb_valid with mdu_wb_rd=9 at t+4; stall released at t+5.
- Second mdu_start_e while busy -> stall_f, stall_d and stall_e high, flush_m high until WB, then accepted with no strobe lost.
- mem_access_m=1, dmem_ready=0 for 3 cycles, with pc_src_e=01 -> all four stalls high, no flush; flush_d and flush_e in the cycle after dmem_ready=1.
- rst mid-BUSY -> next cycle mdu_busy=0, pending all zero, stall_cycles=0, no mdu_wb_valid; with CNT_W=4, 20 stall cycles -> stall_cycles=15.
